// File: rtl/sm_trace_buffer_pkg.sv
// Shared types for the schoolRISCV trace buffer: FSM state encodings and the
// per-instruction record layout (cycle 16 + pc 32 + instr 32 + a0 32 = 112 bits).
package sm_trace_buffer_pkg;

  localparam int CYC_W  = 16;
  localparam int WORD_W = 32;
  localparam int REC_W  = CYC_W + 3 * WORD_W;

  typedef enum logic [1:0] {
    SM_TRACE_IDLE    = 2'd0,
    SM_TRACE_ARMED   = 2'd1,
    SM_TRACE_CAPTURE = 2'd2,
    SM_TRACE_DONE    = 2'd3
  } trace_state_t;

  typedef struct packed {
    logic [CYC_W-1:0]  cycle;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] a0;
  } trace_rec_t;

endpackage

// File: rtl/sm_trace_buffer_if.sv
// Trace-in and drain-out signals of the trace buffer. The slave modport is the
// buffer side; master is the CPU/consumer side.
interface sm_trace_buffer_if;
  import sm_trace_buffer_pkg::*;

  logic              tr_valid;
  logic [WORD_W-1:0] tr_pc;
  logic [WORD_W-1:0] tr_instr;
  logic [WORD_W-1:0] tr_a0;

  logic              rd_valid;
  logic              rd_ready;
  logic [CYC_W-1:0]  rd_cycle;
  logic [WORD_W-1:0] rd_pc;
  logic [WORD_W-1:0] rd_instr;
  logic [WORD_W-1:0] rd_a0;

  modport master (
    output tr_valid, tr_pc, tr_instr, tr_a0, rd_ready,
    input  rd_valid, rd_cycle, rd_pc, rd_instr, rd_a0
  );

  modport slave (
    input  tr_valid, tr_pc, tr_instr, tr_a0, rd_ready,
    output rd_valid, rd_cycle, rd_pc, rd_instr, rd_a0
  );
endinterface

// File: rtl/sm_trace_ram.sv
// Record storage: DEPTH x 112, synchronous write, asynchronous read, no reset
// on contents so it maps onto distributed RAM.
module sm_trace_ram
  import sm_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  trace_rec_t               wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output trace_rec_t               rdata
);

  trace_rec_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/sm_trace_buffer.sv
// PC-triggered pre/post instruction trace window with oldest-first drain.
// Optional ARMED-state timeout is built when SM_TRACE_TIMEOUT_EN is defined.
module sm_trace_buffer
  import sm_trace_buffer_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int POST    = 8,
  parameter int TIMEOUT = 120
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   arm,
  input  logic [WORD_W-1:0]      trig_pc,
  sm_trace_buffer_if.slave       bus,
  output logic [1:0]             state,
  output logic                   triggered,
  output logic                   timeout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sm_trace_buffer: DEPTH must be a power of two >= 4");
  end
  if (POST < 0 || POST > DEPTH - 1) begin : g_bad_post
    $error("sm_trace_buffer: POST out of range");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("sm_trace_buffer: TIMEOUT must be >= 1");
  end

  trace_state_t     r_state;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [CYC_W-1:0] r_cycle;
  logic [AW-1:0]    r_post_cnt;
  logic             r_triggered;

  logic             w_capturing;
  logic             w_we;
  logic             w_hit;
  logic             w_pop;
  logic [AW-1:0]    w_head;
  logic [AW-1:0]    w_post_nx;
  trace_rec_t       w_wrec;
  trace_rec_t       w_rrec;

  assign w_capturing = (r_state == SM_TRACE_ARMED) || (r_state == SM_TRACE_CAPTURE);
  assign w_we        = w_capturing && bus.tr_valid;
  // Only ARMED can trigger; a repeat of trig_pc during CAPTURE is just data.
  assign w_hit       = (r_state == SM_TRACE_ARMED) && bus.tr_valid && (bus.tr_pc == trig_pc);
  assign w_pop       = bus.rd_valid && bus.rd_ready;
  assign w_head      = r_wr_ptr - r_count[AW-1:0];
  assign w_post_nx   = r_post_cnt + 1'b1;

  assign w_wrec = '{cycle: r_cycle, pc: bus.tr_pc, instr: bus.tr_instr, a0: bus.tr_a0};

`ifdef SM_TRACE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] r_to_cnt;
  logic          r_timeout;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= SM_TRACE_IDLE;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_cycle     <= '0;
      r_post_cnt  <= '0;
      r_triggered <= 1'b0;
`ifdef SM_TRACE_TIMEOUT_EN
      r_to_cnt    <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      if (w_capturing) r_cycle <= r_cycle + 1'b1;
      if (w_we) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        // At DEPTH the oldest entry is overwritten, so the window slides.
        if (r_count != CW'(DEPTH)) r_count <= r_count + 1'b1;
      end

      case (r_state)
        SM_TRACE_IDLE: begin
          if (arm) begin
            r_state     <= SM_TRACE_ARMED;
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_cycle     <= '0;
            r_triggered <= 1'b0;
`ifdef SM_TRACE_TIMEOUT_EN
            r_to_cnt    <= '0;
            r_timeout   <= 1'b0;
`endif
          end
        end

        SM_TRACE_ARMED: begin
          if (w_hit) begin
            r_triggered <= 1'b1;
            r_post_cnt  <= '0;
            if (POST == 0) r_state <= SM_TRACE_DONE;
            else           r_state <= SM_TRACE_CAPTURE;
          end
`ifdef SM_TRACE_TIMEOUT_EN
          else if (r_to_cnt == TO_LAST) begin
            r_state   <= SM_TRACE_DONE;
            r_timeout <= 1'b1;
          end else begin
            r_to_cnt  <= r_to_cnt + 1'b1;
          end
`endif
        end

        SM_TRACE_CAPTURE: begin
          if (w_we) begin
            r_post_cnt <= w_post_nx;
            if (w_post_nx == AW'(POST)) r_state <= SM_TRACE_DONE;
          end
        end

        SM_TRACE_DONE: begin
          if (w_pop) r_count <= r_count - 1'b1;
          if (r_count == '0 || (w_pop && r_count == CW'(1))) r_state <= SM_TRACE_IDLE;
        end

        default: r_state <= SM_TRACE_IDLE;
      endcase
    end
  end

  sm_trace_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_wr_ptr),
    .wdata (w_wrec),
    .raddr (w_head),
    .rdata (w_rrec)
  );

  assign bus.rd_valid = (r_state == SM_TRACE_DONE) && (r_count != '0);
  assign bus.rd_cycle = bus.rd_valid ? w_rrec.cycle : '0;
  assign bus.rd_pc    = bus.rd_valid ? w_rrec.pc    : '0;
  assign bus.rd_instr = bus.rd_valid ? w_rrec.instr : '0;
  assign bus.rd_a0    = bus.rd_valid ? w_rrec.a0    : '0;

  assign state     = r_state;
  assign triggered = r_triggered;
  assign count     = r_count;
`ifdef SM_TRACE_TIMEOUT_EN
  assign timeout   = r_timeout;
`else
  assign timeout   = 1'b0;
`endif

endmodule
